spi_master_fifo: RTL and testbench

//  Wishbone-slave SPI master, next generation of the single-byte SPI port: TX/RX FIFOs

---
 rtl/spi_pkg.sv | 48 ++++
 rtl/spi_fifo.sv | 62 ++++++
 rtl/spi_master_fifo.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_spi_master_fifo.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the FIFO-based SPI master.
// Holds the register map, the CTRL/STATUS bit positions, the bus and
// shift-engine state encodings, and the debug struct that exposes both
// state machines at the top level.
package spi_pkg;

  // Register select (adr_i)
  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_CTRL   = 2'd1;
  localparam logic [1:0] ADR_STATUS = 2'd2;
  localparam logic [1:0] ADR_RSVD   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_SEL_LSB = 24;
  localparam int CTRL_DIV_LSB = 16;
  localparam int CTRL_CPHA    = 9;
  localparam int CTRL_CPOL    = 8;
  localparam int CTRL_TX_IE   = 1;
  localparam int CTRL_RX_IE   = 0;

  // STATUS bit positions
  localparam int ST_RXCNT_LSB = 24;
  localparam int ST_TXCNT_LSB = 16;
  localparam int ST_WP        = 5;
  localparam int ST_BUSY      = 4;
  localparam int ST_TX_OVF    = 3;
  localparam int ST_RX_OVF    = 2;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_RX_EMPTY  = 0;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  typedef enum logic {
    ENG_IDLE  = 1'b0,
    ENG_SHIFT = 1'b1
  } eng_state_e;

  // Debug view of both state machines; edge_cnt counts completed SCLK edges.
  typedef struct packed {
    bus_state_e bus;
    eng_state_e eng;
    logic [3:0] edge_cnt;
  } spi_dbg_t;

endpackage

// File: rtl/spi_fifo.sv
// Synchronous FIFO with first-word-fall-through read data.
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset (flushes contents)
//   push, wdata    write request and data; accepted when not full, or when
//                  full and a pop happens in the same cycle
//   pop            read request; ignored while empty
//   rdata          oldest entry (valid while !empty)
//   full, empty    occupancy flags
//   count          number of entries, 0..DEPTH
module spi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when a pop frees the slot this cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_master_fifo.sv
// Wishbone-slave SPI master with TX/RX FIFOs, programmable SCLK divider,
// CPOL/CPHA modes, chip selects, sticky overflow flags and an interrupt.
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   cyc_i, stb_i, we_i   bus cycle, strobe, write enable
//   adr_i, sel_i, dat_i  register select, byte lanes, write data
//   dat_o, ack_o         registered read data, one-cycle acknowledge
//   irq_o                level interrupt (registered)
//   selects              chip selects, active low
//   sclk, mosi, miso     SPI clock, data out, data in
//   wp_n                 flash write-protect status input
//   dbg                  bus and shift-engine state for observation
//
// Bus handshake: a request (cyc_i & stb_i) is sampled only in BUS_IDLE; the
// access takes effect at that edge and ack_o/dat_o are presented for exactly
// the next cycle (BUS_ACK). BUS_ACK always returns to BUS_IDLE, so there is
// one idle cycle between accesses and the master must drop stb_i on ack_o.
module spi_master_fifo
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int NSEL       = 8,
  parameter int DIV_W      = 8,
  parameter int DIV_RESET  = 24
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cyc_i,
  input  logic            stb_i,
  input  logic            we_i,
  input  logic [1:0]      adr_i,
  input  logic [3:0]      sel_i,
  input  logic [31:0]     dat_i,
  output logic [31:0]     dat_o,
  output logic            ack_o,
  output logic            irq_o,
  output logic [NSEL-1:0] selects,
  output logic            sclk,
  output logic            mosi,
  input  logic            miso,
  input  logic            wp_n,
  output spi_dbg_t        dbg
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------- state
  bus_state_e       bus_state;
  eng_state_e       eng_state;

  logic [NSEL-1:0]  ctrl_sel;
  logic [DIV_W-1:0] ctrl_div;
  logic             ctrl_cpol;
  logic             ctrl_cpha;
  logic             tx_ie;
  logic             rx_ie;
  logic             tx_ovf;
  logic             rx_ovf;

  logic [DIV_W-1:0] cur_div;
  logic             cur_cpha;
  logic [DIV_W-1:0] half_cnt;
  logic [3:0]       edge_cnt;
  logic [7:0]       sh_tx;
  logic [7:0]       sh_rx;

  // ---------------------------------------------------------------- FIFOs
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_rdata;
  logic [CW-1:0] tx_count;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_wdata, rx_rdata;
  logic [CW-1:0] rx_count;

  spi_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (tx_push),
    .wdata (dat_i[7:0]),
    .pop   (tx_pop),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  spi_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (rx_push),
    .wdata (rx_wdata),
    .pop   (rx_pop),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // ------------------------------------------------------- control signals
  logic bus_req;
  logic half_done;
  logic last_edge;
  logic sample_now;
  logic busy;
  logic irq_next;
  logic tx_ovf_set;
  logic rx_ovf_set;

  assign bus_req    = (bus_state == BUS_IDLE) & cyc_i & stb_i;
  assign tx_push    = bus_req & we_i & (adr_i == ADR_DATA) & sel_i[0];
  assign rx_pop     = bus_req & ~we_i & (adr_i == ADR_DATA);
  assign tx_pop     = (eng_state == ENG_IDLE) & ~tx_empty;

  assign half_done  = (eng_state == ENG_SHIFT) & (half_cnt == cur_div);
  assign last_edge  = half_done & (edge_cnt == 4'd15);
  // Edge number is edge_cnt+1: odd edges sample when cpha=0, even when cpha=1.
  assign sample_now = (edge_cnt[0] == cur_cpha);

  // With cpha=1 the final bit is sampled on edge 16 itself, so fold miso in.
  assign rx_push    = last_edge;
  assign rx_wdata   = cur_cpha ? {sh_rx[6:0], miso} : sh_rx;

  // Overflow only when the entry is really dropped (no same-cycle pop).
  assign tx_ovf_set = tx_push & tx_full & ~tx_pop;
  assign rx_ovf_set = rx_push & rx_full & ~rx_pop;

  assign busy     = (eng_state == ENG_SHIFT) | ~tx_empty;
  assign irq_next = (rx_ie & ~rx_empty) | (tx_ie & (tx_count == '0) & ~busy);

  assign selects  = ctrl_sel;
  assign dbg      = '{bus: bus_state, eng: eng_state, edge_cnt: edge_cnt};

  // ------------------------------------------------------- read data mux
  logic [31:0] ctrl_word;
  logic [31:0] status_word;
  logic [31:0] rd_data;

  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_SEL_LSB +: NSEL]  = ctrl_sel;
    ctrl_word[CTRL_DIV_LSB +: DIV_W] = ctrl_div;
    ctrl_word[CTRL_CPHA]             = ctrl_cpha;
    ctrl_word[CTRL_CPOL]             = ctrl_cpol;
    ctrl_word[CTRL_TX_IE]            = tx_ie;
    ctrl_word[CTRL_RX_IE]            = rx_ie;
  end

  always_comb begin
    status_word = '0;
    status_word[ST_RXCNT_LSB +: CW] = rx_count;
    status_word[ST_TXCNT_LSB +: CW] = tx_count;
    status_word[ST_WP]              = ~wp_n;
    status_word[ST_BUSY]            = busy;
    status_word[ST_TX_OVF]          = tx_ovf;
    status_word[ST_RX_OVF]          = rx_ovf;
    status_word[ST_TX_FULL]         = tx_full;
    status_word[ST_RX_EMPTY]        = rx_empty;
  end

  always_comb begin
    rd_data = '0;
    case (adr_i)
      ADR_DATA:   if (!rx_empty) rd_data[7:0] = rx_rdata;
      ADR_CTRL:   rd_data = ctrl_word;
      ADR_STATUS: rd_data = status_word;
      default:    rd_data = '0;
    endcase
  end

  // Write data bits outside the defined fields carry no meaning.
  logic unused_dat;
  assign unused_dat = ^dat_i;

  // ------------------------------------------------ bus FSM, CSRs, flags
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bus_state <= BUS_IDLE;
      ack_o     <= 1'b0;
      dat_o     <= '0;
      irq_o     <= 1'b0;
      ctrl_sel  <= '1;
      ctrl_div  <= DIV_RESET[DIV_W-1:0];
      ctrl_cpol <= 1'b0;
      ctrl_cpha <= 1'b0;
      tx_ie     <= 1'b0;
      rx_ie     <= 1'b0;
      tx_ovf    <= 1'b0;
      rx_ovf    <= 1'b0;
    end else begin
      irq_o <= irq_next;
      case (bus_state)
        BUS_IDLE: begin
          ack_o <= 1'b0;
          if (bus_req) begin
            bus_state <= BUS_ACK;
            ack_o     <= 1'b1;
            dat_o     <= we_i ? 32'd0 : rd_data;
            if (we_i) begin
              case (adr_i)
                ADR_CTRL: begin
                  if (sel_i[3]) ctrl_sel <= dat_i[CTRL_SEL_LSB +: NSEL];
                  if (sel_i[2]) ctrl_div <= dat_i[CTRL_DIV_LSB +: DIV_W];
                  if (sel_i[1]) begin
                    ctrl_cpha <= dat_i[CTRL_CPHA];
                    ctrl_cpol <= dat_i[CTRL_CPOL];
                  end
                  if (sel_i[0]) begin
                    tx_ie <= dat_i[CTRL_TX_IE];
                    rx_ie <= dat_i[CTRL_RX_IE];
                  end
                end
                ADR_STATUS: begin
                  if (sel_i[0] && dat_i[ST_TX_OVF]) tx_ovf <= 1'b0;
                  if (sel_i[0] && dat_i[ST_RX_OVF]) rx_ovf <= 1'b0;
                end
                default: ;
              endcase
            end
          end
        end
        BUS_ACK: begin
          ack_o     <= 1'b0;
          bus_state <= BUS_IDLE;
        end
        default: begin
          ack_o     <= 1'b0;
          bus_state <= BUS_IDLE;
        end
      endcase
      // A new overflow in the same cycle as a clear leaves the flag set.
      if (tx_ovf_set) tx_ovf <= 1'b1;
      if (rx_ovf_set) rx_ovf <= 1'b1;
    end
  end

  // --------------------------------------------------------- shift engine
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      eng_state <= ENG_IDLE;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      cur_div   <= '0;
      cur_cpha  <= 1'b0;
      half_cnt  <= '0;
      edge_cnt  <= '0;
      sh_tx     <= '0;
      sh_rx     <= '0;
    end else begin
      case (eng_state)
        ENG_IDLE: begin
          sclk <= ctrl_cpol;
          if (!tx_empty) begin
            eng_state <= ENG_SHIFT;
            cur_div   <= ctrl_div;
            cur_cpha  <= ctrl_cpha;
            half_cnt  <= '0;
            edge_cnt  <= '0;
            sh_rx     <= '0;
            if (ctrl_cpha) begin
              sh_tx <= tx_rdata;
            end else begin
              // cpha=0: first bit must be on the line before edge 1.
              mosi  <= tx_rdata[7];
              sh_tx <= {tx_rdata[6:0], 1'b0};
            end
          end
        end
        ENG_SHIFT: begin
          if (!half_done) begin
            half_cnt <= half_cnt + DIV_W'(1);
          end else begin
            half_cnt <= '0;
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + 4'd1;
            if (sample_now) begin
              sh_rx <= {sh_rx[6:0], miso};
            end else if (edge_cnt != 4'd15) begin
              mosi  <= sh_tx[7];
              sh_tx <= {sh_tx[6:0], 1'b0};
            end
            if (edge_cnt == 4'd15) begin
              eng_state <= ENG_IDLE;
            end
          end
        end
        default: eng_state <= ENG_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo: bus driver tasks, an SPI slave model,
// an SCLK edge monitor and a scoreboard of expected RX bytes.
module tb_spi_master_fifo;
  import spi_pkg::*;

  // ------------------------------------------------ clock / reset
  logic clk = 1'b0;
  logic rst_n;
  initial forever #5 clk = ~clk;

  logic        cyc, stb, we;
  logic [1:0]  adr;
  logic [3:0]  sel;
  logic [31:0] dat_w, dat_r;
  logic        ack, irq;
  logic [7:0]  selects;
  logic        sclk, mosi, miso, wp_n;
  spi_dbg_t    dbg;

  spi_master_fifo #(
    .FIFO_DEPTH(16), .NSEL(8), .DIV_W(8), .DIV_RESET(24)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .cyc_i  (cyc),
    .stb_i  (stb),
    .we_i   (we),
    .adr_i  (adr),
    .sel_i  (sel),
    .dat_i  (dat_w),
    .dat_o  (dat_r),
    .ack_o  (ack),
    .irq_o  (irq),
    .selects(selects),
    .sclk   (sclk),
    .mosi   (mosi),
    .miso   (miso),
    .wp_n   (wp_n),
    .dbg    (dbg)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  // ------------------------------------------------ SPI slave model
  logic       loop_en;
  logic       s_cpol, s_cpha, s_miso;
  logic [7:0] s_tx, s_rx;
  assign miso = loop_en ? mosi : s_miso;

  always @(sclk) begin
    if (selects[0] === 1'b0) begin
      if (sclk !== s_cpol) begin
        if (s_cpha) begin
          s_miso = s_tx[7];
          s_tx   = {s_tx[6:0], 1'b0};
        end else begin
          s_rx = {s_rx[6:0], mosi};
        end
      end else begin
        if (s_cpha) begin
          s_rx = {s_rx[6:0], mosi};
        end else begin
          s_tx   = {s_tx[6:0], 1'b0};
          s_miso = s_tx[7];
        end
      end
    end
  end

  // ------------------------------------------------ SCLK edge monitor
  int   cyc_cnt = 0;
  int   sclk_edges = 0;
  int   first_edge = 0;
  int   last_edge = 0;
  logic sclk_q;
  always @(posedge clk) begin
    cyc_cnt++;
    if (sclk !== sclk_q) begin
      if (sclk_edges == 0) first_edge = cyc_cnt;
      last_edge = cyc_cnt;
      sclk_edges++;
    end
    sclk_q = sclk;
  end

  // ------------------------------------------------ checker / drivers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_cycle(input logic w, input logic [1:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r);
    int waited = 0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!ack && waited < 8);
    check("ack_latency", 32'(waited), 32'd1);
    r = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus_cycle(1'b1, a, d, 4'hF, r);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] r);
    bus_cycle(1'b0, a, 32'd0, 4'hF, r);
  endtask

  task automatic wait_idle(input int max_polls);
    logic [31:0] st;
    int polls = 0;
    do begin
      bus_read(ADR_STATUS, st);
      polls++;
    end while (st[ST_BUSY] && polls < max_polls);
    check("busy_timeout", 32'(st[ST_BUSY]), 32'd0);
  endtask

  task automatic rx_check(input string tag);
    logic [31:0] r;
    logic [7:0]  e;
    bus_read(ADR_DATA, r);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 8'hxx;
    check(tag, r, {24'd0, e});
  endtask

  task automatic clear_edges();
    @(posedge clk); #1;
    sclk_edges = 0;
  endtask

  // ------------------------------------------------ directed sequence
  initial begin
    logic [31:0] r;
    logic [7:0]  txb;
    logic        cpol_v, cpha_v;

    cyc = 0; stb = 0; we = 0; adr = 0; sel = 0; dat_w = 0;
    wp_n = 1; loop_en = 1; s_cpol = 0; s_cpha = 0; s_miso = 0; s_tx = 0; s_rx = 0;

    // Reset held for one clock
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_selects", 32'(selects), 32'hFF);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_dat_o", dat_r, 32'd0);
    check("rst_eng_state", 32'(dbg.eng), 32'(ENG_IDLE));
    bus_read(ADR_STATUS, r);
    check("rst_status", r, 32'h0000_0001);
    @(posedge clk); #1;
    check("ack_one_cycle", 32'(ack), 32'd0);
    bus_read(ADR_CTRL, r);
    check("rst_ctrl", r, 32'hFF18_0000);
    bus_write(ADR_RSVD, 32'hDEAD_BEEF);
    bus_read(ADR_RSVD, r);
    check("adr3_reads_zero", r, 32'd0);
    wp_n = 0;
    bus_read(ADR_STATUS, r);
    check("status_wp", r, 32'h0000_0021);
    wp_n = 1;

    // Mode 0, div 0, loopback
    bus_write(ADR_CTRL, 32'hFF00_0000);
    clear_edges();
    bus_write(ADR_DATA, 32'h0000_00A5);
    exp_q.push_back(8'hA5);
    wait_idle(50);
    check("m0_edges", 32'(sclk_edges), 32'd16);
    check("m0_span", 32'(last_edge - first_edge), 32'd15);
    check("m0_sclk_idle", 32'(sclk), 32'd0);
    rx_check("m0_rx");
    bus_read(ADR_DATA, r);
    check("rx_empty_read", r, 32'd0);
    bus_read(ADR_STATUS, r);
    check("m0_status_after", r, 32'h0000_0001);

    // Modes 1..3 against the slave model, div 3
    for (int m = 1; m < 4; m++) begin
      cpol_v = m[1];
      cpha_v = m[0];
      txb = 8'h96 ^ 8'(m);
      bus_write(ADR_CTRL, {8'hFF, 8'd3, 6'd0, cpha_v, cpol_v, 8'd0});
      repeat (3) @(posedge clk);
      #1;
      loop_en = 0; s_cpol = cpol_v; s_cpha = cpha_v;
      s_tx = 8'h3C; s_rx = 8'h00; s_miso = s_tx[7];
      bus_write(ADR_CTRL, {8'hFE, 8'd3, 6'd0, cpha_v, cpol_v, 8'd0});
      check("mode_selects", 32'(selects), 32'hFE);
      clear_edges();
      bus_write(ADR_DATA, {24'd0, txb});
      exp_q.push_back(8'h3C);
      wait_idle(100);
      check($sformatf("mode%0d_slave_rx", m), 32'(s_rx), 32'(txb));
      check($sformatf("mode%0d_edges", m), 32'(sclk_edges), 32'd16);
      check($sformatf("mode%0d_span", m), 32'(last_edge - first_edge), 32'd60);
      check($sformatf("mode%0d_sclk_idle", m), 32'(sclk), 32'(cpol_v));
      rx_check($sformatf("mode%0d_master_rx", m));
      bus_write(ADR_CTRL, {8'hFF, 8'd3, 6'd0, cpha_v, cpol_v, 8'd0});
    end

    // Burst: byte 0 moves into the shifter, bytes 1..16 fill the TX FIFO,
    // byte 17 is dropped. 17 bytes reach RX, whose 17th push overflows.
    loop_en = 1;
    bus_write(ADR_CTRL, 32'hFF0F_0000);
    for (int i = 0; i < 17; i++) begin
      bus_write(ADR_DATA, 32'(i));
      if (i < 16) exp_q.push_back(8'(i));
    end
    bus_read(ADR_STATUS, r);
    check("burst_tx_full", r, 32'h0010_0013);
    bus_write(ADR_DATA, 32'd17);
    bus_read(ADR_STATUS, r);
    check("burst_tx_ovf", r, 32'h0010_001B);
    wait_idle(4000);
    bus_read(ADR_STATUS, r);
    check("burst_rx_ovf", r, 32'h1000_000C);
    bus_write(ADR_STATUS, 32'h0000_0004);
    bus_read(ADR_STATUS, r);
    check("clear_rx_ovf", r, 32'h1000_0008);
    bus_write(ADR_STATUS, 32'h0000_0008);
    bus_read(ADR_STATUS, r);
    check("clear_tx_ovf", r, 32'h1000_0000);
    for (int i = 0; i < 16; i++) rx_check($sformatf("burst_rx_%0d", i));
    bus_read(ADR_STATUS, r);
    check("burst_drained", r, 32'h0000_0001);

    // RX interrupt
    bus_write(ADR_CTRL, 32'hFF00_0001);
    @(posedge clk); #1;
    check("irq_rx_idle", 32'(irq), 32'd0);
    bus_write(ADR_DATA, 32'h0000_003E);
    exp_q.push_back(8'h3E);
    wait_idle(50);
    @(posedge clk); #1;
    check("irq_rx_set", 32'(irq), 32'd1);
    rx_check("irq_rx_data");
    check("irq_before_drop", 32'(irq), 32'd1);
    @(posedge clk); #1;
    check("irq_rx_clear", 32'(irq), 32'd0);

    // TX-empty interrupt
    bus_write(ADR_CTRL, 32'hFF00_0002);
    @(posedge clk); #1;
    check("irq_tx_empty", 32'(irq), 32'd1);
    bus_write(ADR_CTRL, 32'hFF00_0000);
    repeat (2) @(posedge clk);
    #1;
    check("irq_disabled", 32'(irq), 32'd0);

    // Reset in the middle of a byte
    bus_write(ADR_CTRL, 32'hFE03_0000);
    bus_write(ADR_DATA, 32'h0000_00F0);
    bus_write(ADR_DATA, 32'h0000_000F);
    repeat (20) @(posedge clk);
    #1;
    check("mid_busy", 32'(dbg.eng), 32'(ENG_SHIFT));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_sclk", 32'(sclk), 32'd0);
    check("mid_rst_selects", 32'(selects), 32'hFF);
    check("mid_rst_eng", 32'(dbg.eng), 32'(ENG_IDLE));
    bus_read(ADR_STATUS, r);
    check("mid_rst_status", r, 32'h0000_0001);
    bus_read(ADR_DATA, r);
    check("mid_rst_rx", r, 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
